// File: rtl/vector_memory_reader.sv
// Fetches a run of consecutive 128-bit vectors from the RAM vector port
// and hands each one to vector writeback over a valid/ready handshake.
module vector_memory_reader #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LANE_W  = 16,
  parameter int unsigned LANES   = 8,
  parameter int unsigned COUNT_W = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_address,
  input  logic [COUNT_W-1:0]        vector_count,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_W-1:0]         mem_address,
  output logic                      mem_read_enable,
  input  logic [LANES*LANE_W-1:0]   mem_q,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*LANE_W-1:0]   out_vector,
  output logic [COUNT_W-1:0]        out_index
);

  localparam int unsigned VEC_W  = LANES * LANE_W;
  localparam int unsigned CNT1_W = COUNT_W + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_CAPTURE = 3'd2,
    S_PRESENT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t               r_state;
  logic [COUNT_W-1:0]   r_index;
  logic [COUNT_W-1:0]   r_count;
  logic [ADDR_W-1:0]    r_addr;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_rd_en;
  logic                 r_valid;
  logic [VEC_W-1:0]     r_vector;
  logic [COUNT_W-1:0]   r_out_index;

  state_t               w_state_nxt;
  logic [COUNT_W-1:0]   w_index_nxt;
  logic [COUNT_W-1:0]   w_count_nxt;
  logic [ADDR_W-1:0]    w_addr_nxt;
  logic                 w_valid_nxt;
  logic [VEC_W-1:0]     w_vector_nxt;
  logic [COUNT_W-1:0]   w_out_index_nxt;
  logic                 w_last;
  logic                 w_xfer;

  // Extra bit keeps index+1 from aliasing onto a count of 0.
  assign w_last = (CNT1_W'(r_index) + CNT1_W'(1)) == CNT1_W'(r_count);
  assign w_xfer = r_valid && out_ready;

  // Next-state and next-value logic; every output is registered below.
  always_comb begin
    w_state_nxt     = r_state;
    w_index_nxt     = r_index;
    w_count_nxt     = r_count;
    w_addr_nxt      = r_addr;
    w_valid_nxt     = r_valid;
    w_vector_nxt    = r_vector;
    w_out_index_nxt = r_out_index;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_count_nxt = vector_count;
          if (vector_count != '0) begin
            w_addr_nxt  = base_address;
            w_index_nxt = '0;
            w_state_nxt = S_ISSUE;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_vector_nxt    = mem_q;
        w_out_index_nxt = r_index;
        w_valid_nxt     = 1'b1;
        w_state_nxt     = S_PRESENT;
      end
      S_PRESENT: begin
        if (w_xfer) begin
          w_valid_nxt = 1'b0;
          if (w_last) begin
            w_state_nxt = S_DONE;
          end else begin
            w_index_nxt = r_index + COUNT_W'(1);
            w_addr_nxt  = r_addr + ADDR_W'(1);
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; status flags are decoded from next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_index     <= '0;
      r_count     <= '0;
      r_addr      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_valid     <= 1'b0;
      r_vector    <= '0;
      r_out_index <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_index     <= w_index_nxt;
      r_count     <= w_count_nxt;
      r_addr      <= w_addr_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_DONE);
      r_rd_en     <= (w_state_nxt == S_ISSUE);
      r_valid     <= w_valid_nxt;
      r_vector    <= w_vector_nxt;
      r_out_index <= w_out_index_nxt;
    end
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign mem_address     = r_addr;
  assign mem_read_enable = r_rd_en;
  assign out_valid       = r_valid;
  assign out_vector      = r_vector;
  assign out_index       = r_out_index;

endmodule

// File: tb/tb_vector_memory_reader.sv
// Self-checking bench for vector_memory_reader: directed table runs, reset
// sequences and randomized runs checked against a run-level reference model.
module tb_vector_memory_reader;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned LANE_W  = 16;
  localparam int unsigned LANES   = 8;
  localparam int unsigned COUNT_W = 4;
  localparam int unsigned VEC_W   = LANES * LANE_W;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [ADDR_W-1:0]   base_address;
  logic [COUNT_W-1:0]  vector_count;
  logic                busy;
  logic                done;
  logic [ADDR_W-1:0]   mem_address;
  logic                mem_read_enable;
  logic [VEC_W-1:0]    mem_q;
  logic                out_valid;
  logic                out_ready;
  logic [VEC_W-1:0]    out_vector;
  logic [COUNT_W-1:0]  out_index;

  logic [VEC_W-1:0]    ram [0:255];
  int                  cyc = 0;
  int                  errors = 0;
  int                  checks = 0;

  typedef struct {
    logic [7:0] base;
    logic [3:0] count;
    int         stall;
    int         exp_done;
  } vec_t;

  vector_memory_reader #(
    .ADDR_W(ADDR_W), .LANE_W(LANE_W), .LANES(LANES), .COUNT_W(COUNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_address(base_address),
    .vector_count(vector_count), .busy(busy), .done(done),
    .mem_address(mem_address), .mem_read_enable(mem_read_enable),
    .mem_q(mem_q), .out_valid(out_valid), .out_ready(out_ready),
    .out_vector(out_vector), .out_index(out_index)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // One-cycle-latency RAM; garbage on the read port when not enabled.
  always @(posedge clk) begin
    if (mem_read_enable) mem_q <= ram[mem_address];
    else                 mem_q <= {$urandom, $urandom, $urandom, $urandom};
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Runs one command; called and returns at a negedge. rnd selects random
  // back-pressure plus ignored start pulses, with the done time predicted as
  // three cycles per vector plus one per stalled presentation cycle.
  task automatic run_one(input logic [7:0] base, input logic [3:0] count,
                         input int stall, input bit rnd, input int exp_done_tbl);
    int e, n_xfer, n_rd, n_stall, n_tbl_stall, off, exp_done;
    bit got_done, held;
    logic [VEC_W-1:0] held_vec;
    logic [COUNT_W-1:0] held_idx;
    start = 1'b1; base_address = base; vector_count = count; out_ready = 1'b1;
    e = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0; base_address = 8'($urandom); vector_count = 4'($urandom);
    got_done = 0; held = 0; n_xfer = 0; n_rd = 0; n_stall = 0; n_tbl_stall = 0; off = -1;
    held_vec = '0; held_idx = '0;
    for (int t = 0; t < 300 && !got_done; t++) begin
      @(negedge clk);
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      else if (out_valid && n_tbl_stall < stall) begin
        out_ready = 1'b0; n_tbl_stall++;
      end else out_ready = 1'b1;
      chk("busy_in_run", 128'(busy), 128'(1));
      if (out_valid) begin
        if (held) begin
          chk("vector_stable", out_vector, held_vec);
          chk("index_stable", 128'(out_index), 128'(held_idx));
        end else begin
          held = 1; held_vec = out_vector; held_idx = out_index;
        end
      end
      if (mem_read_enable) begin
        chk("read_address", 128'(mem_address), 128'(8'(base + n_rd)));
        chk("read_while_presenting", 128'(out_valid), 128'(0));
        n_rd++;
      end
      if (out_valid && out_ready) begin
        chk("out_vector", out_vector, ram[8'(base + n_xfer)]);
        chk("out_index", 128'(out_index), 128'(n_xfer));
        n_xfer++; held = 0;
      end else if (out_valid) n_stall++;
      if (done) begin
        got_done = 1; off = cyc - e;
        start = 1'b0;
      end else if (rnd) begin
        start = 1'($urandom_range(0, 1));
        base_address = 8'($urandom); vector_count = 4'($urandom);
      end
    end
    start = 1'b0; out_ready = 1'b1;
    if (!got_done) chk("done_timeout", 128'(0), 128'(1));
    exp_done = rnd ? ((count == 0) ? 0 : 3 * int'(count) + n_stall) : exp_done_tbl;
    chk("done_cycle", 128'(off), 128'(exp_done));
    chk("transfer_count", 128'(n_xfer), 128'(count));
    chk("read_count", 128'(n_rd), 128'(count));
    @(negedge clk);
    chk("idle_after_done", 128'({busy, done}), 128'(0));
  endtask

  initial begin
    vec_t tbl [6];
    bit found;

    for (int a = 0; a < 256; a++) ram[a] = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < LANES; i++) begin
      ram[8'h10][LANE_W*i +: LANE_W] = 16'(i + 1);
      ram[8'h11][LANE_W*i +: LANE_W] = 16'h1111;
      ram[8'h12][LANE_W*i +: LANE_W] = 16'hFFFF;
    end

    tbl[0] = '{8'h10, 4'd3,  0, 9};
    tbl[1] = '{8'h10, 4'd3,  5, 14};
    tbl[2] = '{8'hFE, 4'd3,  0, 9};
    tbl[3] = '{8'h00, 4'd0,  0, 0};
    tbl[4] = '{8'h20, 4'd1,  0, 3};
    tbl[5] = '{8'h40, 4'd15, 2, 47};

    // Reset held with random inputs: every output must be zero.
    reset = 1'b0; start = 1'b0; base_address = '0; vector_count = '0; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'($urandom); base_address = 8'($urandom);
      vector_count = 4'($urandom); out_ready = 1'($urandom);
      #1;
      chk("reset_ctrl", 128'({busy, done, mem_address, mem_read_enable, out_valid, out_index}), 128'(0));
      chk("reset_vector", out_vector, 128'(0));
    end
    @(negedge clk);
    reset = 1'b1; start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_no_start", 128'({busy, mem_read_enable}), 128'(0));
    end

    // Lane order of the first basic-run vector, from plain lane constants.
    chk("lane0_const", 128'(ram[8'h10][15:0]), 128'(16'h0001));
    chk("lane7_const", 128'(ram[8'h10][127:112]), 128'(16'h0008));

    for (int k = 0; k < 6; k++)
      run_one(tbl[k].base, tbl[k].count, tbl[k].stall, 1'b0, tbl[k].exp_done);

    // Reset asserted during the second PRESENT of a four-vector run.
    start = 1'b1; base_address = 8'h30; vector_count = 4'd4; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int t = 0; t < 50 && !found; t++) begin
      @(negedge clk);
      if (out_valid && out_index == 4'd1) found = 1;
    end
    chk("second_present_reached", 128'(found), 128'(1));
    reset = 1'b0;
    #1;
    chk("midrun_reset_ctrl", 128'({busy, done, mem_address, mem_read_enable, out_valid, out_index}), 128'(0));
    chk("midrun_reset_vector", out_vector, 128'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_done_in_reset", 128'({busy, done}), 128'(0));
    end
    reset = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 128'({busy, done, mem_read_enable}), 128'(0));
    run_one(8'h20, 4'd1, 0, 1'b0, 3);

    // Randomized runs with random back-pressure and start pulses while busy.
    for (int r = 0; r < 20; r++)
      run_one(8'($urandom), 4'($urandom_range(0, 6)), 0, 1'b1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vector_memory_reader.md
# vector_memory_reader

Read-side counterpart of the vector memory loader. On a start command it fetches a run of consecutive 128-bit vectors from the vector RAM port, with one-cycle synchronous read latency. Each vector is presented to the vector writeback path over a valid/ready handshake, packed as eight 16-bit lanes. The block sits beside the RAM vector port (address_b/q_b) and feeds vector register writeback.

## Interface
Parameters:
- ADDR_W, 8, vector RAM address width
- LANE_W, 16, lane width
- LANES, 8, lanes per vector (vector width = LANES*LANE_W = 128)
- COUNT_W, 4, width of vector count and index

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  command strobe, sampled only in IDLE
- base_address  input  ADDR_W  first vector address, captured with start
- vector_count  input  COUNT_W  number of vectors to read, captured with start
- busy  output  1  high whenever state is not IDLE
- done  output  1  single-cycle pulse after the last vector transfers
- mem_address  output  ADDR_W  registered read address to RAM vector port
- mem_read_enable  output  1  high in ISSUE state only
- mem_q  input  LANES*LANE_W  RAM read data, valid the cycle after the address is sampled
- out_valid  output  1  out_vector/out_index hold a vector
- out_ready  input  1  consumer accepts the vector
- out_vector  output  LANES*LANE_W  lane i at bits [LANE_W*i+LANE_W-1 : LANE_W*i]; lane 0 at [15:0]
- out_index  output  COUNT_W  0-based position of out_vector within the run

## Operation
- States: IDLE, ISSUE, CAPTURE, PRESENT, DONE.
- IDLE:
  - start=1 with vector_count≠0 → latch base_address into mem_address, clear index → ISSUE.
  - start=1 with vector_count=0 → DONE; no RAM read is issued.
  - start=0 → remain in IDLE.
- ISSUE: mem_read_enable=1 and mem_address stable; RAM samples the address at the end of this cycle → CAPTURE.
- CAPTURE: register mem_q into out_vector and the index into out_index, set out_valid → PRESENT.
- PRESENT: out_valid stays high and out_vector/out_index stay frozen until out_valid&&out_ready at a rising edge. On transfer:
  - clear out_valid;
  - if index+1 == captured count → DONE;
  - else increment index, mem_address+1 (mod 2^ADDR_W, wraps 0xFF→0x00) → ISSUE.
- DONE: done=1 for exactly one cycle → IDLE.
- start while busy is ignored. base_address and vector_count are used only at the accepting edge; later changes have no effect.
- out_ready while out_valid=0 has no effect.
- mem_q is sampled only in CAPTURE; its value in other cycles is ignored.
- Lane order matches the vector ALU lane order used by the loader, so a loader write followed by a reader fetch returns identical lanes.
- Reset asserted mid-run (reset=0):
  - immediate return to IDLE;
  - every output goes to 0;
  - the run is abandoned and done is not pulsed.

## Timing
- Reset values: busy=0, done=0, mem_address=0, mem_read_enable=0, out_valid=0, out_vector=0, out_index=0.
- start accepted at edge E:
  - ISSUE during cycle E→E+1;
  - data captured at edge E+2;
  - out_valid high from E+2.
- With out_ready held high, each vector transfers 3 cycles after its ISSUE begins; steady-state throughput is one vector per 3 cycles.
- Run of N vectors with out_ready=1: done is high in the cycle beginning at edge E+3N, and busy falls at edge E+3N+1.
- A new start is accepted no earlier than the edge that returns the block to IDLE, i.e. the cycle after done.
- vector_count=0: done pulses in the cycle after E and busy is high for that single cycle.
- Back-pressure adds one cycle per cycle of out_ready=0 in PRESENT. Outputs are glitch-free (all registered).

## Test plan
- Reset: hold reset=0 with random inputs → every output 0. Release reset, start=0 for 10 cycles → block stays IDLE, mem_read_enable never 1.
- Basic run: preload RAM[0x10..0x12] with lanes 0x0001..0x0008, 0x1111 per lane, 0xFFFF per lane. start, base=0x10, count=3, out_ready=1.
  - out_vector sequence matches, out_index 0,1,2.
  - mem_address 0x10,0x11,0x12.
  - done at edge E+9.
- Back-pressure: same run, out_ready=0 for 5 cycles during the first PRESENT → out_vector/out_index stable and no new mem_read_enable during the stall; done is delayed by exactly 5 cycles.
- Wrap and boundaries:
  - base=0xFE, count=3 → addresses 0xFE,0xFF,0x00.
  - count=0 → one-cycle done, no read.
  - start pulses while busy → ignored.
- Reset mid-run: count=4, assert reset=0 during the second PRESENT → all outputs 0 immediately and no done pulse. After release, a new start with base=0x20, count=1 completes normally.
